// File: rtl/echo_width_meter.sv
// ---------------------------------------------------------------------------
// echo_width_meter
//
// Ultrasonic range-sensor front end. A start request fires a fixed-width
// trigger pulse at the sensor, then the block times how long the sensor's
// echo line stays high, in clock cycles. The result is reported with a
// one-cycle valid strobe, or a timeout strobe when no complete echo arrives
// inside the timeout window.
//
// Optional feature macro: ECHO_HOLDOFF_EN
//   defined   : after every result the block stays busy in a HOLDOFF state so
//               the sensor cannot be re-triggered during its ring-down time.
//   undefined : the block returns to IDLE straight after the result.
// ---------------------------------------------------------------------------
module echo_width_meter #(
    parameter int TRIG_COUNTS    = 1250,     // trigger high time, cycles
    parameter int TIMEOUT_COUNTS = 3750000,  // trigger end to echo fall limit
    parameter int HOLDOFF_COUNTS = 7500000,  // re-arm lockout after a result
    parameter int CNT_W          = 24        // counter and result width
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             echo,
    output logic             trig,
    output logic             busy,
    output logic [CNT_W-1:0] width,
    output logic             valid,
    output logic             timeout
);

    // -----------------------------------------------------------------------
    // Elaboration-time parameter sanity checks. The holdoff length must be at
    // least 2 because the DONE cycle counts as the first lockout cycle; it is
    // checked in both builds so the macro alone can switch the feature on.
    // -----------------------------------------------------------------------
    if (TRIG_COUNTS < 1) begin : g_bad_trig
        $error("echo_width_meter: TRIG_COUNTS must be >= 1");
    end
    if (TIMEOUT_COUNTS < 1) begin : g_bad_timeout_min
        $error("echo_width_meter: TIMEOUT_COUNTS must be >= 1");
    end
    if (longint'(TIMEOUT_COUNTS) >= (longint'(1) << CNT_W)) begin : g_bad_timeout_max
        $error("echo_width_meter: TIMEOUT_COUNTS must be < 2**CNT_W");
    end
    if (HOLDOFF_COUNTS < 2) begin : g_bad_holdoff
        $error("echo_width_meter: HOLDOFF_COUNTS must be >= 2");
    end

    // -----------------------------------------------------------------------
    // Counter widths and terminal values
    // -----------------------------------------------------------------------
    localparam int TRIG_W = (TRIG_COUNTS > 1) ? $clog2(TRIG_COUNTS) : 1;

    localparam logic [TRIG_W-1:0] TRIG_LAST    = TRIG_W'(TRIG_COUNTS - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_COUNTS - 1);
    localparam logic [CNT_W-1:0]  WIDTH_MAX    = {CNT_W{1'b1}};

`ifdef ECHO_HOLDOFF_EN
    localparam int HOLD_W = $clog2(HOLDOFF_COUNTS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_COUNTS - 1);
`endif

    // -----------------------------------------------------------------------
    // FSM state encoding
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_DONE      = 3'd4
`ifdef ECHO_HOLDOFF_EN
        ,
        ST_HOLDOFF   = 3'd5
`endif
    } state_t;

    state_t            state_reg;

    // Registered outputs
    logic              trig_reg;
    logic              busy_reg;
    logic [CNT_W-1:0]  width_reg;
    logic              valid_reg;
    logic              timeout_reg;

    // Counters
    logic [TRIG_W-1:0] trig_cnt_reg;
    logic [CNT_W-1:0]  timeout_cnt_reg;
    logic [CNT_W-1:0]  width_cnt_reg;
`ifdef ECHO_HOLDOFF_EN
    logic [HOLD_W-1:0] hold_cnt_reg;
`endif

    // Echo synchronizer: [0] and [1] are the two metastability flops, [2] is
    // the previous synchronized value used for edge detection.
    logic [2:0]        echo_sync_reg;
    logic              echo_s;
    logic              echo_prev;
    logic              echo_rise;
    logic              echo_fall;

    // Two-flop synchronizer plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            echo_sync_reg <= 3'b000;
        end else begin
            echo_sync_reg <= {echo_sync_reg[1:0], echo};
        end
    end

    assign echo_s    = echo_sync_reg[1];
    assign echo_prev = echo_sync_reg[2];
    assign echo_rise = echo_s & ~echo_prev;
    assign echo_fall = ~echo_s & echo_prev;

    // Measurement sequencer: trigger, wait for echo, time it, report, re-arm
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            trig_reg        <= 1'b0;
            busy_reg        <= 1'b0;
            width_reg       <= '0;
            valid_reg       <= 1'b0;
            timeout_reg     <= 1'b0;
            trig_cnt_reg    <= '0;
            timeout_cnt_reg <= '0;
            width_cnt_reg   <= '0;
`ifdef ECHO_HOLDOFF_EN
            hold_cnt_reg    <= '0;
`endif
        end else begin
            // Result strobes are single-cycle by default
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg    <= ST_TRIG;
                        trig_reg     <= 1'b1;
                        busy_reg     <= 1'b1;
                        trig_cnt_reg <= '0;
                    end
                end

                ST_TRIG: begin
                    // Trigger rose on the accepting edge, so it falls on the
                    // TRIG_COUNTS-th edge afterwards.
                    if (trig_cnt_reg == TRIG_LAST) begin
                        state_reg       <= ST_WAIT_RISE;
                        trig_reg        <= 1'b0;
                        timeout_cnt_reg <= '0;
                    end else begin
                        trig_cnt_reg <= trig_cnt_reg + TRIG_W'(1);
                    end
                end

                ST_WAIT_RISE: begin
                    // Only a true rising edge starts a measurement, so an echo
                    // that was already high when the trigger ended must first
                    // drop and rise again. Expiry beats a coincident rise
                    // because nothing could be measured afterwards anyway.
                    if (timeout_cnt_reg == TIMEOUT_LAST) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= ST_DONE;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + CNT_W'(1);
                        if (echo_rise) begin
                            state_reg     <= ST_MEASURE;
                            width_cnt_reg <= CNT_W'(1);
                        end
                    end
                end

                ST_MEASURE: begin
                    // The timeout window keeps running from the trigger end;
                    // a fall on the expiry edge still counts as a good result.
                    if (echo_fall) begin
                        width_reg <= width_cnt_reg;
                        valid_reg <= 1'b1;
                        state_reg <= ST_DONE;
                    end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= ST_DONE;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + CNT_W'(1);
                        if (echo_s && (width_cnt_reg != WIDTH_MAX)) begin
                            width_cnt_reg <= width_cnt_reg + CNT_W'(1);
                        end
                    end
                end

                ST_DONE: begin
`ifdef ECHO_HOLDOFF_EN
                    // The DONE cycle is the first cycle of the lockout, so
                    // busy stays high HOLDOFF_COUNTS cycles from the strobe.
                    state_reg    <= ST_HOLDOFF;
                    hold_cnt_reg <= HOLD_W'(1);
`else
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
`endif
                end

`ifdef ECHO_HOLDOFF_EN
                ST_HOLDOFF: begin
                    if (hold_cnt_reg == HOLD_LAST) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                    end
                end
`endif

                default: begin
                    state_reg <= ST_IDLE;
                    trig_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign trig    = trig_reg;
    assign busy    = busy_reg;
    assign width   = width_reg;
    assign valid   = valid_reg;
    assign timeout = timeout_reg;

endmodule

// File: doc/echo_width_meter.md
# echo_width_meter

Ultrasonic range-sensor front end for the RC platform, running on the 125 MHz system clock. On a `start` pulse it drives a fixed-width trigger pulse to the sensor, then measures how long the sensor's `echo` line stays high, in clock cycles. It reports the result with a one-cycle `valid` strobe, or a `timeout` strobe if the echo does not arrive in time. Where the delay timer turns a start event into an elapsed-time event, this block turns an external event back into an elapsed-time count.

## Interface
- `TRIG_COUNTS`, 1250: trigger high time in cycles (10 µs at 125 MHz).
- `TIMEOUT_COUNTS`, 3750000: maximum cycles from trigger end to echo fall (30 ms).
- `HOLDOFF_COUNTS`, 7500000: cycles of re-arm lockout after a result (60 ms); used only with `ECHO_HOLDOFF_EN`.
- `CNT_W`, 24: width of counters and `width`. Requires `TIMEOUT_COUNTS` < 2^`CNT_W`.

- `clk` in 1: system clock. One clock domain.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request a measurement; sampled only in IDLE.
- `echo` in 1: asynchronous sensor echo line.
- `trig` out 1: sensor trigger, registered.
- `busy` out 1: high in every state except IDLE.
- `width` out `CNT_W`: cycles `echo` was high in the last successful measurement. Held until the next `valid`.
- `valid` out 1: one-cycle strobe; `width` is updated on the same edge.
- `timeout` out 1: one-cycle strobe; the measurement failed and `width` is unchanged.

## Operation
- `echo` passes through a 2-flop synchronizer to give `echo_s`. Edge detection compares `echo_s` with its previous value.
- FSM states and transitions:
  - IDLE
    - `start`=1 → TRIG, counter cleared.
  - TRIG
    - `trig`=1.
    - After `TRIG_COUNTS` cycles → WAIT_RISE, with the timeout counter cleared.
  - WAIT_RISE
    - Rising edge of `echo_s` → MEASURE, with `width_cnt`=1.
    - If `echo_s` is already high on entry, the block waits for a low followed by a rising edge.
  - MEASURE
    - `width_cnt` increments each cycle `echo_s` stays high, saturating at 2^`CNT_W`−1.
    - Falling edge of `echo_s`: `width`←`width_cnt`, `valid` pulses → DONE.
  - Timeout, in WAIT_RISE or MEASURE
    - When the timeout counter reaches `TIMEOUT_COUNTS`−1: `timeout` pulses → DONE.
  - DONE
    - → IDLE, or → HOLDOFF when `ECHO_HOLDOFF_EN` is defined.
- The timeout counter runs continuously through WAIT_RISE and MEASURE and is not restarted on the echo rise.
- Simultaneous echo fall and timeout expiry: `valid` wins and `timeout` stays 0.
- `start` outside IDLE is ignored and is not queued.
- Reset at any time returns to IDLE within one edge and aborts any pulse in progress.
- Reset values: `trig`=0, `busy`=0, `width`=0, `valid`=0, `timeout`=0, all counters 0.

## Timing
- `start` is high at edge 0: `trig` and `busy` go high after edge 0. `trig` stays high for exactly `TRIG_COUNTS` cycles.
- Synchronizer latency is 2 cycles on both edges. `width` therefore equals the raw echo high time ±1 cycle.
- `valid` asserts 3 cycles after the raw `echo` falls.
- `valid` and `timeout` are mutually exclusive and never assert on consecutive cycles.
- `busy` falls one cycle after the `valid`/`timeout` strobe, or at the end of HOLDOFF when it is enabled.
- A `start` on the same cycle `busy` falls is ignored. The earliest accepted `start` is the following cycle.

## Configuration
- `ECHO_HOLDOFF_EN` defined:
  - DONE → HOLDOFF for `HOLDOFF_COUNTS` cycles, with `busy`=1 and `start` ignored.
  - This blocks sensor re-triggering inside the sensor's echo ring-down time.
- `ECHO_HOLDOFF_EN` undefined:
  - DONE → IDLE directly.
  - The HOLDOFF state and its counter are absent, and `HOLDOFF_COUNTS` is unused.

## Test plan
Bench parameters: `TRIG_COUNTS`=4, `TIMEOUT_COUNTS`=100, `HOLDOFF_COUNTS`=20, `CNT_W`=8.
- Reset, then idle for 10 cycles:
  - all outputs are 0.
  - `start` pulsed → `trig` high exactly 4 cycles and `busy`=1.
- Echo raised 10 cycles after `trig` falls and held high 37 cycles:
  - `valid` pulses once, 3 cycles after the echo fall.
  - `width`=37 (±1).
  - `timeout` stays 0.
- Echo never rises:
  - `timeout` pulses on the 100th cycle after `trig` falls.
  - `width` keeps its previous value and `valid` stays 0.
- Echo rises 50 cycles after `trig` falls and never falls:
  - `timeout` at cycle 100 and `width` unchanged.
  - Repeat with the echo fall timed to coincide with expiry → `valid` only.
- `start` pulsed during MEASURE and again during HOLDOFF:
  - both are ignored.
  - `busy` stays high for 20 cycles after the strobe with `ECHO_HOLDOFF_EN`, and for 1 cycle without it.
- `reset` asserted mid-TRIG and again mid-MEASURE:
  - next cycle `trig`=0, `busy`=0, no strobes.
  - a new `start` runs a full, correct measurement.
